// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the staged reset sequencer.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } seq_state_e;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_POR  = 2'b00;
  localparam cause_t CAUSE_PLL  = 2'b01;
  localparam cause_t CAUSE_USER = 2'b10;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Sequencer bus: async request inputs in, per-channel resets and status out.
// slave = the sequencer itself, master = whoever drives the request lines.
interface reset_sequencer_if #(
  parameter int CHANNELS = 3
);
  logic                pll_locked;
  logic                user_reset_n;
  logic [CHANNELS-1:0] reset_out;
  logic                sequence_done;
  logic [1:0]          last_cause;
  logic [7:0]          reset_count;

  modport master (
    output pll_locked, user_reset_n,
    input  reset_out, sequence_done, last_cause, reset_count
  );

  modport slave (
    input  pll_locked, user_reset_n,
    output reset_out, sequence_done, last_cause, reset_count
  );
endinterface

// File: rtl/reset_input_sync.sv
// 2-flop synchroniser for the active-low user button, optional debounce.
// Macro RESET_SEQUENCER_DEBOUNCE_EN: press only after DEBOUNCE_CYCLES
// continuous synced-low cycles; otherwise synced low is a press at once.
// Flops hold "pressed" (inverted input) so their reset value means idle.
module reset_input_sync #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk_1x,
  input  logic reset_1x,
  input  logic din_n,
  output logic pressed
);
  logic [1:0] sync_q;

  // two-stage synchroniser of the inverted button level
  always_ff @(posedge clk_1x or posedge reset_1x) begin
    if (reset_1x) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], ~din_n};
  end

`ifdef RESET_SEQUENCER_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES);

  logic [DW-1:0] db_cnt;

  // count continuous pressed samples, saturate at the threshold
  always_ff @(posedge clk_1x or posedge reset_1x) begin
    if (reset_1x)              db_cnt <= '0;
    else if (!sync_q[1])       db_cnt <= '0;
    else if (db_cnt != DB_LAST) db_cnt <= db_cnt + 1'b1;
  end

  assign pressed = (db_cnt == DB_LAST);
`else
  assign pressed = sync_q[1];
`endif

endmodule

// File: rtl/reset_sequencer.sv
// Staged multi-channel reset sequencer with cause tracking.
// Optional user-button debounce via macro RESET_SEQUENCER_DEBOUNCE_EN.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int CHANNELS        = 3,
  parameter int INITIAL_DELAY   = 64,
  parameter int STAGE_DELAY     = 16,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input logic               clk_1x,
  input logic               reset_1x,
  reset_sequencer_if.slave  bus
);
  localparam int CW = $clog2(max_i(INITIAL_DELAY, STAGE_DELAY) + 1);
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // WAIT compares before counting, so channel 0 falls one edge after the
  // count reaches INITIAL_DELAY; RELEASE releases on the edge where the
  // count would reach STAGE_DELAY, giving exact STAGE_DELAY spacing.
  localparam logic [CW-1:0] INIT_LAST  = CW'(INITIAL_DELAY);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(CHANNELS - 2);

  seq_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [CHANNELS-1:0] rst_q, rst_d;
  logic                done_q, done_d;
  cause_t              cause_q, cause_d;
  logic [7:0]          count_q, count_d;

  logic [1:0] pll_sync;
  logic       pll_ok, user_press, req, abort;

  // PLL lock is never debounced: plain 2-flop synchroniser
  always_ff @(posedge clk_1x or posedge reset_1x) begin
    if (reset_1x) pll_sync <= 2'b00;
    else          pll_sync <= {pll_sync[0], bus.pll_locked};
  end

  assign pll_ok = pll_sync[1];

  reset_input_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_user_sync (
    .clk_1x   (clk_1x),
    .reset_1x (reset_1x),
    .din_n    (bus.user_reset_n),
    .pressed  (user_press)
  );

  assign req   = ~pll_ok | user_press;
  assign abort = req && (state_q != HOLD);

  // state and datapath registers
  always_ff @(posedge clk_1x or posedge reset_1x) begin
    if (reset_1x) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  // next-state: any request outside HOLD aborts back to HOLD
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HOLD:    if (!req) state_d = WAIT;
      WAIT:    if (req) state_d = HOLD;
               else if (cnt_q == INIT_LAST)
                 state_d = (CHANNELS == 1) ? DONE : RELEASE;
      RELEASE: if (req) state_d = HOLD;
               else if (cnt_q == STAGE_LAST && stage_q == LAST_STAGE)
                 state_d = DONE;
      DONE:    if (req) state_d = HOLD;
      default: state_d = HOLD;
    endcase
  end

  // next values of counter, stage and registered outputs
  always_comb begin
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    done_d  = done_q;
    cause_d = cause_q;
    count_d = count_q;
    if (abort) begin
      cnt_d   = '0;
      stage_d = '0;
      rst_d   = '1;
      done_d  = 1'b0;
      cause_d = pll_ok ? CAUSE_USER : CAUSE_PLL;
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
    end else begin
      unique case (state_q)
        HOLD: begin
          cnt_d   = '0;
          stage_d = '0;
          rst_d   = '1;
          done_d  = 1'b0;
        end
        WAIT: begin
          if (cnt_q == INIT_LAST) begin
            cnt_d    = '0;
            stage_d  = '0;
            rst_d[0] = 1'b0;
            if (CHANNELS == 1) done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RELEASE: begin
          if (cnt_q == STAGE_LAST) begin
            cnt_d   = '0;
            stage_d = stage_q + 1'b1;
            for (int i = 1; i < CHANNELS; i++)
              if (i == int'(stage_q) + 1) rst_d[i] = 1'b0;
            if (stage_q == LAST_STAGE) done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.reset_out     = rst_q;
  assign bus.sequence_done = done_q;
  assign bus.last_cause    = cause_q;
  assign bus.reset_count   = count_q;

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Multi-channel reset sequencer that replaces the single fixed-duration generator with ordered, staged release of `CHANNELS` reset outputs. Each channel releases a fixed delay after the previous one, for example memory controller first, then CPU, then video. Reset re-entry triggers on PLL lock loss or a user reset button, and the block records the cause. It sits at the top level between the PLL and every clock-domain reset distribution point.

## Interface
Parameters:
- `CHANNELS`, 3: number of reset outputs; legal range 1..8.
- `INITIAL_DELAY`, 64: cycles from stable lock/no-request to release of channel 0; must be ≥1.
- `STAGE_DELAY`, 16: cycles between release of channel i and channel i+1; must be ≥1.
- `DEBOUNCE_CYCLES`, 1024: cycles `user_reset_n` must stay low to count as a press. Used only with `RESET_SEQUENCER_DEBOUNCE_EN`.

Ports:
- `clk_1x`  in  1  sole clock; all logic on rising edge.
- `reset_1x`  in  1  asynchronous, active-high reset.
- `pll_locked`  in  1  asynchronous; synchronised internally with 2 flops.
- `user_reset_n`  in  1  asynchronous, active-low button; synchronised internally with 2 flops.
- `reset_out`  out  CHANNELS  active-high per-channel resets; bit 0 releases first.
- `sequence_done`  out  1  high once all channels are released.
- `last_cause`  out  2  cause of the most recent HOLD entry: 00 power-on, 01 PLL loss, 10 user, 11 unused.
- `reset_count`  out  8  saturating count of re-entries into HOLD caused by PLL loss or user.

## Operation
- Request condition `req`: synced `pll_locked` is low, or a user press is detected.
- States: HOLD, WAIT, RELEASE, DONE.
- Counter width is `$clog2(max(INITIAL_DELAY, STAGE_DELAY)+1)`. Stage index width is `$clog2(CHANNELS)`, minimum 1 bit.
- HOLD: all `reset_out` bits are 1. Counter is cleared. Move to WAIT when `req` is low.
- WAIT: counter increments each cycle. When counter reaches `INITIAL_DELAY`, clear `reset_out[0]`, clear the counter, set stage to 0, and go to RELEASE. If `CHANNELS`=1, go directly to DONE instead.
- RELEASE: counter increments each cycle. When counter reaches `STAGE_DELAY`, clear `reset_out[stage+1]` and increment stage. When the last channel is cleared, go to DONE.
- DONE: `sequence_done`=1. Outputs are held.
- `req` high in any state other than HOLD:
  - Next edge enters HOLD and sets all `reset_out` bits to 1 simultaneously.
  - `sequence_done` goes to 0.
  - `last_cause` is updated; PLL loss has priority over user when both occur in the same cycle.
  - `reset_count` increments, saturating at 255.
- `req` high while already in HOLD: stay in HOLD. No count increment; `last_cause` is unchanged.
- A user press held indefinitely keeps the block in HOLD. Release starts only after the button is released.
- `reset_out` bits change only from registered logic, never combinationally.

## Timing
- Values while `reset_1x` is asserted:
  - State HOLD.
  - `reset_out` all 1.
  - `sequence_done`=0.
  - `last_cause`=00.
  - `reset_count`=0.
  - Synchroniser flops = 0, meaning not locked and not pressed.
- Synchroniser latency is 2 edges. One further edge is needed to leave HOLD.
- With `pll_locked` going high and no press, `reset_out[0]` falls on edge 3+`INITIAL_DELAY`, counted from the first edge that samples `pll_locked` high.
- `reset_out[i]` falls exactly `STAGE_DELAY` edges after `reset_out[i-1]`.
- `sequence_done` rises on the same edge that `reset_out[CHANNELS-1]` falls.
- Abort latency: `pll_locked` falling re-asserts all outputs 3 edges after the first sample of the low level (2 sync edges + 1 state edge).
- `reset_1x` asserted mid-sequence: all outputs go to their reset values immediately and asynchronously.

## Configuration
- `RESET_SEQUENCER_DEBOUNCE_EN` defined:
  - A press is recognised only after synced `user_reset_n` has been continuously low for `DEBOUNCE_CYCLES` cycles.
  - Any high sample restarts the debounce count.
  - Press recognition latency is 2+`DEBOUNCE_CYCLES` edges.
- Not defined:
  - Synced low `user_reset_n` is a press immediately, after 2 edges.
  - The `DEBOUNCE_CYCLES` parameter is ignored and no debounce counter is synthesised.

## Structure
- `reset_sequencer_pkg` holds:
  - The state enum typedef (HOLD, WAIT, RELEASE, DONE).
  - The cause encodings as named constants: `CAUSE_POR`, `CAUSE_PLL`, `CAUSE_USER`.
- One sub-module, `reset_input_sync`: a 2-flop synchroniser with an optional debounce counter controlled by the macro.
  - Instantiated once for `user_reset_n`.
  - The `pll_locked` path uses a plain 2-flop synchroniser inline; PLL loss is never debounced.

## Test plan
All scenarios use `CHANNELS`=3, `INITIAL_DELAY`=8, `STAGE_DELAY`=4, `DEBOUNCE_CYCLES`=16.
- Power-on sequence: release `reset_1x`, then raise `pll_locked` at edge 0 → `reset_out` goes 111→110 at edge 11, →100 at edge 15, →000 at edge 19; `sequence_done`=1 at edge 19; `last_cause`=00, `reset_count`=0.
- PLL loss after DONE: drop `pll_locked` for 5 cycles → `reset_out`=111 three edges after the drop; `last_cause`=01, `reset_count`=1; full re-sequence follows the relock.
- User press mid-RELEASE: hold `user_reset_n` low for 20 cycles while `reset_out`=110 → all outputs 111; `last_cause`=10; HOLD lasts until the release, then `reset_out[0]` falls 11 edges after the first high sample.
- Debounce (macro on): 10-cycle low glitch on `user_reset_n` → no change in outputs or count. With the macro off, the same glitch forces HOLD.
- Simultaneous events: PLL loss and user press in the same cycle → `last_cause`=01 and `reset_count` increments by exactly 1. Also assert `reset_1x` mid-WAIT → outputs 111 and count 0 immediately.
